// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package vmem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ   = 2;
    // Holds RD_LAT-1, so two bits cover read latencies 1..4.
    localparam int LAT_CNT_W = 2;

endpackage

// File: rtl/vmem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the one not served last wins.
module rr_arb2
    import vmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/vmem_port_arbiter.sv
// Shares one split-strobe memory port between two requesters with round-robin grant
// and a single outstanding read whose registered response returns to its owner.
//
// state   | meaning
// IDLE    | accepting requests; grant drives the memory port in the same cycle
// RD_WAIT | read in flight, counting down to the cycle memory data is valid
module vmem_port_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  mem_w_en,
    output logic [AW-1:0]         mem_w_addr,
    output logic [DW-1:0]         mem_w_data,
    output logic                  mem_r_en,
    output logic [AW-1:0]         mem_r_addr,
    input  logic [DW-1:0]         mem_r_data
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("vmem_port_arbiter: RD_LAT must be within 1..4");
    end

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT - 1);

    arb_state_t             state_q, state_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q;
    logic                   owner_q;
    logic                   rr_last_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [DW-1:0]          rsp_rdata_q;

    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant;
    logic                   any_grant;
    logic                   grant_idx;
    logic                   sel_we;
    logic [AW-1:0]          sel_addr;
    logic [DW-1:0]          sel_wdata;
    logic                   rd_issue;

    // No grants while reset is held or while a read is outstanding.
    assign arb_req = (rst && state_q == IDLE) ? req_valid : '0;

    rr_arb2 u_rr_arb2 (
        .req   (arb_req),
        .last  (rr_last_q),
        .grant (grant)
    );

    assign any_grant = |grant;
    assign grant_idx = grant[1];
    assign sel_we    = grant_idx ? req_we[1] : req_we[0];
    assign sel_addr  = grant_idx ? req_addr[AW +: AW] : req_addr[0 +: AW];
    assign sel_wdata = grant_idx ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
    assign rd_issue  = any_grant && !sel_we;

    always_comb begin
        state_d    = state_q;
        req_ready  = grant;
        mem_w_en   = 1'b0;
        mem_w_addr = '0;
        mem_w_data = '0;
        mem_r_en   = 1'b0;
        mem_r_addr = '0;
        case (state_q)
            IDLE: begin
                if (any_grant) begin
                    if (sel_we) begin
                        mem_w_en   = 1'b1;
                        mem_w_addr = sel_addr;
                        mem_w_data = sel_wdata;
                    end else begin
                        mem_r_en   = 1'b1;
                        mem_r_addr = sel_addr;
                        state_d    = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            owner_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            if (any_grant) begin
                rr_last_q <= grant_idx;
            end
            if (rd_issue) begin
                owner_q   <= grant_idx;
                lat_cnt_q <= LAT_INIT;
            end
            if (state_q == RD_WAIT) begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_q <= lat_cnt_q - LAT_CNT_W'(1);
                end else begin
                    rsp_rdata_q <= mem_r_data;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
